// File: rtl/alu_control_if.sv
// Handshake and decoded-control bundle between the fetch/issue side, the decoder and the ALU.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready for instructions, out_valid/out_ready for controls, flags_valid for branch flags.
interface alu_control_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  control;
    logic        alu_src;
    logic        auipc;
    logic        lui;
    logic [31:0] immediate;
    logic        is_branch;
    logic        illegal;
    logic        flags_valid;
    logic        zero;
    logic        br_valid;
    logic        br_taken;

    // Decoder side
    modport slave (
        input  in_valid, instr, out_ready, flags_valid, zero,
        output in_ready, out_valid, control, alu_src, auipc, lui, immediate,
               is_branch, illegal, br_valid, br_taken
    );

    // Issue/ALU side
    modport master (
        output in_valid, instr, out_ready, flags_valid, zero,
        input  in_ready, out_valid, control, alu_src, auipc, lui, immediate,
               is_branch, illegal, br_valid, br_taken
    );
endinterface

// File: rtl/alu_control.sv
// RV32I ALU-control decoder with conditional-branch resolution.
// Latency: controls valid 1 cycle after acceptance; br_valid pulses 1 cycle after flags_valid.
// Backpressure: one instruction in flight; in_ready stays low until out_ready (and branch flags) retire it.
module alu_control (
    input  logic         clk,
    input  logic         rst,
    alu_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, BR_WAIT = 2'd2, BR_DONE = 2'd3} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    state_t state_q, state_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]  control_d, control_q;
    logic        alu_src_d, alu_src_q;
    logic        auipc_d, auipc_q;
    logic        lui_d, lui_q;
    logic [31:0] imm_d, imm_q;
    logic        is_branch_d, is_branch_q;
    logic        illegal_d, illegal_q;
    logic        br_inv_d, br_inv_q;
    logic        br_taken_d, br_taken_q;
    logic        accept;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_b = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
    assign imm_u = {bus.instr[31:12], 12'b0};
    assign imm_j = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};

    assign accept = (state_q == IDLE) && bus.in_valid;

    // BNE/BLT/BLTU take the branch on a clear zero flag; funct3[0]^funct3[2] marks those.
    assign br_inv_d   = funct3[0] ^ funct3[2];
    assign br_taken_d = bus.zero ^ br_inv_q;

    // Combinational decode of the presented instruction word.
    always_comb begin
        control_d   = 4'b0000;
        alu_src_d   = 1'b0;
        auipc_d     = 1'b0;
        lui_d       = 1'b0;
        imm_d       = 32'b0;
        is_branch_d = 1'b0;
        illegal_d   = 1'b0;
        case (opcode)
            OP_R: begin
                if ((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
                    control_d = {funct7[5], funct3};
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_IMM: begin
                alu_src_d = 1'b1;
                control_d = {(funct3 == 3'b101) & funct7[5], funct3};
                imm_d     = (funct3[1:0] == 2'b01) ? {27'b0, bus.instr[24:20]} : imm_i;
            end
            OP_LOAD, OP_JALR: begin
                alu_src_d = 1'b1;
                imm_d     = imm_i;
            end
            OP_STORE: begin
                alu_src_d = 1'b1;
                imm_d     = imm_s;
            end
            OP_JAL: begin
                alu_src_d = 1'b1;
                imm_d     = imm_j;
            end
            OP_LUI: begin
                alu_src_d = 1'b1;
                lui_d     = 1'b1;
                imm_d     = imm_u;
            end
            OP_AUIPC: begin
                alu_src_d = 1'b1;
                auipc_d   = 1'b1;
                imm_d     = imm_u;
            end
            OP_BRANCH: begin
                if (funct3[2:1] == 2'b01) begin
                    illegal_d = 1'b1;
                end else begin
                    is_branch_d = 1'b1;
                    imm_d       = imm_b;
                    control_d   = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
                end
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)    state_d = HOLD;
            HOLD:    if (bus.out_ready)   state_d = is_branch_q ? BR_WAIT : IDLE;
            BR_WAIT: if (bus.flags_valid) state_d = BR_DONE;
            BR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the decoded controls when an instruction is accepted; they hold through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            control_q   <= 4'b0000;
            alu_src_q   <= 1'b0;
            auipc_q     <= 1'b0;
            lui_q       <= 1'b0;
            imm_q       <= 32'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            br_inv_q    <= 1'b0;
        end else if (accept) begin
            control_q   <= control_d;
            alu_src_q   <= alu_src_d;
            auipc_q     <= auipc_d;
            lui_q       <= lui_d;
            imm_q       <= imm_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
            br_inv_q    <= br_inv_d;
        end
    end

    // Latch the branch outcome when the ALU flags arrive for the issued branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_taken_q <= 1'b0;
        end else if ((state_q == BR_WAIT) && bus.flags_valid) begin
            br_taken_q <= br_taken_d;
        end
    end

    // State-derived handshake outputs and registered control outputs.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == HOLD);
        bus.br_valid  = (state_q == BR_DONE);
        bus.br_taken  = br_taken_q;
        bus.control   = control_q;
        bus.alu_src   = alu_src_q;
        bus.auipc     = auipc_q;
        bus.lui       = lui_q;
        bus.immediate = imm_q;
        bus.is_branch = is_branch_q;
        bus.illegal   = illegal_q;
    end
endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed for RV32I.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  instr is valid this cycle.
REQ-005 in_ready  output  1  block can accept an instruction.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  decoded ALU controls are valid.
REQ-008 out_ready  input  1  ALU stage consumes the decoded controls.
REQ-009 control  output  4  ALU opcode: ADD 0000, SUB 1000, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011.
REQ-010 alu_src  output  1  selects immediate as second operand.
REQ-011 auipc  output  1  selects pc as first operand.
REQ-012 lui  output  1  forces first operand to zero.
REQ-013 immediate  output  32  decoded immediate.
REQ-014 is_branch  output  1  decoded instruction is a conditional branch.
REQ-015 illegal  output  1  opcode/funct combination is not supported.
REQ-016 flags_valid  input  1  ALU zero flag for the issued branch is valid.
REQ-017 zero  input  1  ALU zero flag.
REQ-018 br_valid  output  1  one-cycle pulse; br_taken is valid.
REQ-019 br_taken  output  1  branch resolution result.

Function
REQ-020 FSM states SHALL be IDLE, HOLD, BR_WAIT and BR_DONE.
REQ-021 in_ready SHALL be 1 only in IDLE; in_valid in any other state SHALL be ignored.
REQ-022 IDLE with in_valid=1 SHALL register all decoded outputs and go to HOLD, so out_valid rises the cycle after acceptance (latency 1).
REQ-023 In HOLD: out_valid=1; control, alu_src, auipc, lui, immediate, is_branch and illegal SHALL stay stable until out_ready=1.
REQ-024 HOLD with out_ready=1 SHALL go to BR_WAIT if is_branch=1, otherwise to IDLE.
REQ-025 BR_WAIT with flags_valid=1 SHALL latch br_taken and go to BR_DONE; flags_valid in any other state SHALL be ignored.
REQ-026 BR_DONE SHALL assert br_valid for exactly one cycle and then return to IDLE.
REQ-027 Branch decode: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
REQ-028 br_taken: BEQ = zero; BNE = !zero; BLT/BLTU = !zero; BGE/BGEU = zero.
REQ-029 R-type (0110011): control = {funct7[5], funct3}; alu_src = 0.
REQ-030 OP-IMM (0010011): control = {funct3==101 ? funct7[5] : 0, funct3}; alu_src = 1.
REQ-031 Shift-immediate (funct3 001/101) immediate SHALL be {27'b0, instr[24:20]}.
REQ-032 Load, store, JALR, LUI and AUIPC SHALL use control ADD with alu_src = 1.
REQ-033 Immediates SHALL follow the RV32I I/S/B/U/J formats, sign-extended from instr[31]; U-type SHALL be {instr[31:12], 12'b0}.
REQ-034 auipc SHALL be 1 only for opcode 0010111; lui SHALL be 1 only for opcode 0110111.
REQ-035 Unsupported opcode, branch funct3 010/011, or R-type funct7 other than 0000000/0100000 (0100000 only with funct3 000/101) SHALL set illegal=1, control=ADD, is_branch=0, and follow the non-branch path.

Reset
REQ-036 With rst=1 at a clock edge, the FSM SHALL enter IDLE.
REQ-037 With rst=1 at a clock edge, all outputs except in_ready SHALL clear to 0 and in_ready SHALL be 1.
REQ-038 rst SHALL take priority over every handshake in the same cycle, including mid-HOLD and mid-BR_WAIT.

Verification
REQ-039 ADD x3,x1,x2 (0x002081B3) accepted -> next cycle out_valid=1, control=0000, alu_src=0, is_branch=0.
REQ-040 SRAI x5,x6,3 (0x40335293) -> control=1101, alu_src=1, immediate=0x00000003.
REQ-041 BLT (0xFE20CCE3), out_ready=1, then flags_valid=1 with zero=0 -> control=0010, immediate=0xFFFFFFF8, then one-cycle br_valid=1 with br_taken=1.
REQ-042 LUI x1,0x12345 (0x123450B7), out_ready held 0 for 3 cycles -> outputs stable, in_ready=0, lui=1, immediate=0x12345000; returns to IDLE after out_ready=1.
REQ-043 instr 0x00000000 -> illegal=1, control=0000, no br_valid pulse.
REQ-044 rst asserted in BR_WAIT -> next cycle in_ready=1, out_valid=0, br_valid=0, and a later flags_valid=1 is ignored.
